// File: rtl/i2c_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
// Holds the FSM state encoding and the mid-frame classification helper.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_ADDR     = 3'd1;
    localparam logic [2:0] ENC_ADDR_ACK = 3'd2;
    localparam logic [2:0] ENC_DATA     = 3'd3;
    localparam logic [2:0] ENC_DATA_ACK = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ENC_IDLE,
        ST_ADDR     = ENC_ADDR,
        ST_ADDR_ACK = ENC_ADDR_ACK,
        ST_DATA     = ENC_DATA,
        ST_DATA_ACK = ENC_DATA_ACK
    } i2c_state_t;

    // A START/STOP here interrupts a byte or its acknowledge slot.
    function automatic logic i2c_mid_frame(input i2c_state_t st, input logic [2:0] bit_cnt);
        case (st)
            ST_ADDR, ST_DATA:         return (bit_cnt != 3'd0);
            ST_ADDR_ACK, ST_DATA_ACK: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter for one I2C line.
// The filtered output follows only after FILTER_LEN consecutive differing samples.
module i2c_line_filter #(
    parameter int   FILTER_LEN = 3,
    parameter logic RESET_VAL  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    logic       sync1_r;
    logic       sync2_r;
    logic       filt_r;
    logic [3:0] cnt_r;

    // Synchronise the raw pin and qualify changes over FILTER_LEN samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r <= RESET_VAL;
            sync2_r <= RESET_VAL;
            filt_r  <= RESET_VAL;
            cnt_r   <= 4'd0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != filt_r) begin
                if (cnt_r == 4'(FILTER_LEN - 1)) begin
                    filt_r <= sync2_r;
                    cnt_r  <= 4'd0;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                end
            end else begin
                cnt_r <= 4'd0;
            end
        end
    end

    assign filtered = filt_r;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C monitor: conditions SDA/SCL, detects START/STOP and decodes
// address, R/W, data bytes and acknowledge bits. Never drives the bus.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int                    FILTER_LEN = 3,
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50,
    parameter int                    CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sda,
    input  logic                  scl,
    output logic                  start_p,
    output logic                  stop_p,
    output logic                  busy,
    output logic [I2C_ADDR_W-1:0] addr,
    output logic                  rw,
    output logic                  addr_valid,
    output logic                  addr_match,
    output logic [I2C_BYTE_W-1:0] data,
    output logic                  data_valid,
    output logic                  ack,
    output logic                  ack_valid,
    output logic [CNT_W-1:0]      byte_cnt,
    output logic                  frame_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic sda_f_s, scl_f_s, sda_q_r, scl_q_r;
    logic start_ev_s, stop_ev_s, scl_rise_s;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_sda_filter (
        .clk(clk), .reset(reset), .raw(sda), .filtered(sda_f_s)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_scl_filter (
        .clk(clk), .reset(reset), .raw(scl), .filtered(scl_f_s)
    );

    assign start_ev_s = scl_f_s & scl_q_r & sda_q_r & ~sda_f_s;
    assign stop_ev_s  = scl_f_s & scl_q_r & ~sda_q_r & sda_f_s;
    assign scl_rise_s = scl_f_s & ~scl_q_r;

    i2c_state_t              state_r, state_s;
    logic [2:0]              bit_cnt_r, bit_cnt_s;
    logic [6:0]              shift_r, shift_s;
    logic                    start_p_r, start_p_s, stop_p_r, stop_p_s, busy_r, busy_s;
    logic [I2C_ADDR_W-1:0]   addr_r, addr_s;
    logic                    rw_r, rw_s, addr_valid_r, addr_valid_s, match_r, match_s;
    logic [I2C_BYTE_W-1:0]   data_r, data_s;
    logic                    data_valid_r, data_valid_s, ack_r, ack_s, ack_valid_r, ack_valid_s;
    logic [CNT_W-1:0]        byte_cnt_r, byte_cnt_s;
    logic                    frame_err_r, frame_err_s;

    // Next-state and next-output decode; bus conditions take priority over bit sampling.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        start_p_s    = 1'b0;
        stop_p_s     = 1'b0;
        busy_s       = busy_r;
        addr_s       = addr_r;
        rw_s         = rw_r;
        addr_valid_s = 1'b0;
        match_s      = match_r;
        data_s       = data_r;
        data_valid_s = 1'b0;
        ack_s        = ack_r;
        ack_valid_s  = 1'b0;
        byte_cnt_s   = byte_cnt_r;
        frame_err_s  = 1'b0;
        if (start_ev_s) begin
            start_p_s   = 1'b1;
            busy_s      = 1'b1;
            state_s     = ST_ADDR;
            bit_cnt_s   = 3'd0;
            frame_err_s = i2c_mid_frame(state_r, bit_cnt_r);
        end else if (stop_ev_s) begin
            stop_p_s    = 1'b1;
            busy_s      = 1'b0;
            state_s     = ST_IDLE;
            bit_cnt_s   = 3'd0;
            frame_err_s = i2c_mid_frame(state_r, bit_cnt_r);
        end else if (scl_rise_s) begin
            case (state_r)
                ST_ADDR: begin
                    shift_s = {shift_r[5:0], sda_f_s};
                    if (bit_cnt_r == 3'd7) begin
                        addr_s       = shift_r;
                        rw_s         = sda_f_s;
                        addr_valid_s = 1'b1;
                        match_s      = (shift_r == SLAVE_ADDR);
                        byte_cnt_s   = '0;
                        bit_cnt_s    = 3'd0;
                        state_s      = ST_ADDR_ACK;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_DATA: begin
                    shift_s = {shift_r[5:0], sda_f_s};
                    if (bit_cnt_r == 3'd7) begin
                        data_s       = {shift_r, sda_f_s};
                        data_valid_s = 1'b1;
                        byte_cnt_s   = (byte_cnt_r == CNT_MAX) ? byte_cnt_r : byte_cnt_r + CNT_ONE;
                        bit_cnt_s    = 3'd0;
                        state_s      = ST_DATA_ACK;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    ack_s       = ~sda_f_s;
                    ack_valid_s = 1'b1;
                    state_s     = ST_DATA;
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, edge history and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sda_q_r      <= 1'b1;
            scl_q_r      <= 1'b1;
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 7'd0;
            start_p_r    <= 1'b0;
            stop_p_r     <= 1'b0;
            busy_r       <= 1'b0;
            addr_r       <= '0;
            rw_r         <= 1'b0;
            addr_valid_r <= 1'b0;
            match_r      <= 1'b0;
            data_r       <= '0;
            data_valid_r <= 1'b0;
            ack_r        <= 1'b0;
            ack_valid_r  <= 1'b0;
            byte_cnt_r   <= '0;
            frame_err_r  <= 1'b0;
        end else begin
            sda_q_r      <= sda_f_s;
            scl_q_r      <= scl_f_s;
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            start_p_r    <= start_p_s;
            stop_p_r     <= stop_p_s;
            busy_r       <= busy_s;
            addr_r       <= addr_s;
            rw_r         <= rw_s;
            addr_valid_r <= addr_valid_s;
            match_r      <= match_s;
            data_r       <= data_s;
            data_valid_r <= data_valid_s;
            ack_r        <= ack_s;
            ack_valid_r  <= ack_valid_s;
            byte_cnt_r   <= byte_cnt_s;
            frame_err_r  <= frame_err_s;
        end
    end

    assign start_p    = start_p_r;
    assign stop_p     = stop_p_r;
    assign busy       = busy_r;
    assign addr       = addr_r;
    assign rw         = rw_r;
    assign addr_valid = addr_valid_r;
    assign addr_match = match_r;
    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign ack        = ack_r;
    assign ack_valid  = ack_valid_r;
    assign byte_cnt   = byte_cnt_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: a bit-banged master drives the bus,
// a negedge monitor counts pulses, and each scenario task checks its results.
module tb_i2c_bus_monitor;
    import i2c_pkg::*;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sda = 1'b1;
    logic       scl = 1'b1;
    logic       start_p, stop_p, busy, rw, addr_valid, addr_match, data_valid, ack, ack_valid, frame_err;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] byte_cnt;
    logic       start_p2, stop_p2, busy2, rw2, addr_valid2, addr_match2, data_valid2, ack2, ack_valid2, frame_err2;
    logic [6:0] addr2;
    logic [7:0] data2;
    logic [1:0] byte_cnt2;

    int n_checks = 0;
    int n_pass = 0;
    int n_start = 0, n_stop = 0, n_addr_v = 0, n_data_v = 0, n_ack_v = 0, n_ack1 = 0;
    int n_ferr = 0, n_ferr_stop = 0;
    logic [7:0] data_log [0:63];
    int s_start, s_stop, s_addr_v, s_data_v, s_ack_v, s_ack1, s_ferr, s_ferr_stop;

    always #5 clk = ~clk;

    i2c_bus_monitor #(.FILTER_LEN(3), .SLAVE_ADDR(7'h50), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .start_p(start_p), .stop_p(stop_p), .busy(busy), .addr(addr), .rw(rw),
        .addr_valid(addr_valid), .addr_match(addr_match), .data(data),
        .data_valid(data_valid), .ack(ack), .ack_valid(ack_valid),
        .byte_cnt(byte_cnt), .frame_err(frame_err)
    );

    i2c_bus_monitor #(.FILTER_LEN(3), .SLAVE_ADDR(7'h50), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .start_p(start_p2), .stop_p(stop_p2), .busy(busy2), .addr(addr2), .rw(rw2),
        .addr_valid(addr_valid2), .addr_match(addr_match2), .data(data2),
        .data_valid(data_valid2), .ack(ack2), .ack_valid(ack_valid2),
        .byte_cnt(byte_cnt2), .frame_err(frame_err2)
    );

    always @(negedge clk) begin
        if (start_p) n_start <= n_start + 1;
        if (stop_p) n_stop <= n_stop + 1;
        if (addr_valid) n_addr_v <= n_addr_v + 1;
        if (data_valid) begin
            data_log[n_data_v[5:0]] <= data;
            n_data_v <= n_data_v + 1;
        end
        if (ack_valid) n_ack_v <= n_ack_v + 1;
        if (ack_valid && ack) n_ack1 <= n_ack1 + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
        if (frame_err && stop_p) n_ferr_stop <= n_ferr_stop + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_start = n_start; s_stop = n_stop; s_addr_v = n_addr_v; s_data_v = n_data_v;
        s_ack_v = n_ack_v; s_ack1 = n_ack1; s_ferr = n_ferr; s_ferr_stop = n_ferr_stop;
    endtask

    task automatic bus_start();
        sda = 1'b1; wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        sda = 1'b0; wait_cyc(H);
        scl = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        wait_cyc(2);
        sda = b; wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        scl = 1'b0;
    endtask

    task automatic bus_byte(input logic [7:0] b, input logic acked);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(~acked);
    endtask

    task automatic bus_stop();
        wait_cyc(2);
        sda = 1'b0; wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        sda = 1'b1; wait_cyc(2 * H);
    endtask

    task automatic test_reset();
        reset = 1'b0; sda = 1'b1; scl = 1'b1;
        wait_cyc(4);
        reset = 1'b1;
        wait_cyc(12);
        n_checks++; if ({start_p, stop_p, addr_valid, data_valid, ack_valid, frame_err} !== 6'd0)
            $display("FAIL reset_pulses: got %b expected 000000", {start_p, stop_p, addr_valid, data_valid, ack_valid, frame_err}); else n_pass++;
        n_checks++; if ({busy, rw, addr_match, ack} !== 4'd0)
            $display("FAIL reset_flags: got %b expected 0000", {busy, rw, addr_match, ack}); else n_pass++;
        n_checks++; if ({addr, data, byte_cnt} !== 23'd0)
            $display("FAIL reset_values: got addr=%0h data=%0h cnt=%0d expected 0", addr, data, byte_cnt); else n_pass++;
        n_checks++; if (n_start + n_stop !== 0)
            $display("FAIL reset_no_events: got %0d expected 0", n_start + n_stop); else n_pass++;
    endtask

    task automatic test_write();
        snap();
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_byte(8'hA5, 1'b1);
        bus_byte(8'h3C, 1'b1);
        wait_cyc(H);
        n_checks++; if (busy !== 1'b1) $display("FAIL write_busy_high: got %b expected 1", busy); else n_pass++;
        bus_stop();
        n_checks++; if (n_addr_v - s_addr_v !== 1) $display("FAIL write_addr_valid: got %0d expected 1", n_addr_v - s_addr_v); else n_pass++;
        n_checks++; if ({addr, rw, addr_match} !== {7'h50, 1'b0, 1'b1})
            $display("FAIL write_addr: got addr=%0h rw=%b match=%b expected 50/0/1", addr, rw, addr_match); else n_pass++;
        n_checks++; if (n_data_v - s_data_v !== 2) $display("FAIL write_data_valid: got %0d expected 2", n_data_v - s_data_v); else n_pass++;
        n_checks++; if (data_log[s_data_v] !== 8'hA5) $display("FAIL write_data0: got %0h expected a5", data_log[s_data_v]); else n_pass++;
        n_checks++; if (data_log[s_data_v + 1] !== 8'h3C) $display("FAIL write_data1: got %0h expected 3c", data_log[s_data_v + 1]); else n_pass++;
        n_checks++; if ((n_ack_v - s_ack_v !== 3) || (n_ack1 - s_ack1 !== 3))
            $display("FAIL write_acks: got %0d/%0d expected 3/3", n_ack_v - s_ack_v, n_ack1 - s_ack1); else n_pass++;
        n_checks++; if (byte_cnt !== 8'd2) $display("FAIL write_byte_cnt: got %0d expected 2", byte_cnt); else n_pass++;
        n_checks++; if (n_stop - s_stop !== 1) $display("FAIL write_stop: got %0d expected 1", n_stop - s_stop); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL write_busy_low: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_repeated_start();
        snap();
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_byte(8'h01, 1'b1);
        wait_cyc(H);
        n_checks++; if (byte_cnt !== 8'd1) $display("FAIL rs_cnt_before: got %0d expected 1", byte_cnt); else n_pass++;
        bus_start();
        bus_byte(8'h51, 1'b0);
        wait_cyc(H);
        n_checks++; if ((n_start - s_start !== 2) || (n_stop - s_stop !== 0))
            $display("FAIL rs_starts: got start=%0d stop=%0d expected 2/0", n_start - s_start, n_stop - s_stop); else n_pass++;
        n_checks++; if ({addr, rw, addr_match} !== {7'h28, 1'b1, 1'b0})
            $display("FAIL rs_addr: got addr=%0h rw=%b match=%b expected 28/1/0", addr, rw, addr_match); else n_pass++;
        n_checks++; if (byte_cnt !== 8'd0) $display("FAIL rs_cnt_after: got %0d expected 0", byte_cnt); else n_pass++;
        n_checks++; if (ack !== 1'b0) $display("FAIL rs_nack: got %b expected 0", ack); else n_pass++;
        bus_stop();
    endtask

    task automatic test_glitch();
        snap();
        wait_cyc(4);
        sda = 1'b0; wait_cyc(2); sda = 1'b1;
        wait_cyc(20);
        n_checks++; if ((n_start - s_start !== 0) || (n_stop - s_stop !== 0))
            $display("FAIL glitch_short: got start=%0d stop=%0d expected 0/0", n_start - s_start, n_stop - s_stop); else n_pass++;
        sda = 1'b0; wait_cyc(4); sda = 1'b1;
        wait_cyc(20);
        n_checks++; if (n_start - s_start !== 1)
            $display("FAIL glitch_long: got start=%0d expected 1", n_start - s_start); else n_pass++;
    endtask

    task automatic test_frame_err();
        bus_stop();
        snap();
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b0);
        bus_stop();
        n_checks++; if ((n_ferr - s_ferr !== 1) || (n_ferr_stop - s_ferr_stop !== 1))
            $display("FAIL ferr_with_stop: got ferr=%0d same=%0d expected 1/1", n_ferr - s_ferr, n_ferr_stop - s_ferr_stop); else n_pass++;
        n_checks++; if (n_addr_v - s_addr_v !== 0)
            $display("FAIL ferr_no_addr: got %0d expected 0", n_addr_v - s_addr_v); else n_pass++;
        n_checks++; if (dut.state_r !== ST_IDLE)
            $display("FAIL ferr_state: got %0d expected %0d", dut.state_r, ST_IDLE); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1);
        reset = 1'b0;
        wait_cyc(2);
        scl = 1'b1; sda = 1'b1;
        wait_cyc(4);
        reset = 1'b1;
        snap();
        wait_cyc(20);
        n_checks++; if ((n_start + n_stop + n_addr_v + n_data_v + n_ack_v + n_ferr) !==
                        (s_start + s_stop + s_addr_v + s_data_v + s_ack_v + s_ferr))
            $display("FAIL rmid_no_pulses: got events after release, expected none"); else n_pass++;
        n_checks++; if ({busy, addr, rw, addr_match, data, ack, byte_cnt} !== 27'd0)
            $display("FAIL rmid_outputs: got addr=%0h data=%0h cnt=%0d busy=%b expected 0", addr, data, byte_cnt, busy); else n_pass++;
        bus_start();
        bus_byte(8'hA0, 1'b1);
        bus_byte(8'h5A, 1'b1);
        bus_stop();
        n_checks++; if ({addr, rw, addr_match, data, byte_cnt} !== {7'h50, 1'b0, 1'b1, 8'h5A, 8'd1})
            $display("FAIL rmid_resume: got addr=%0h rw=%b match=%b data=%0h cnt=%0d expected 50/0/1/5a/1",
                     addr, rw, addr_match, data, byte_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        bus_start();
        bus_byte(8'hA0, 1'b1);
        for (int i = 0; i < 5; i++) bus_byte(8'(8'h10 + i), 1'b1);
        bus_stop();
        n_checks++; if (byte_cnt2 !== 2'd3) $display("FAIL sat_cnt2: got %0d expected 3", byte_cnt2); else n_pass++;
        n_checks++; if (byte_cnt !== 8'd5) $display("FAIL sat_cnt8: got %0d expected 5", byte_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_repeated_start();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Passive, parametrised I2C bus monitor: samples raw `sda`/`scl` on the system clock, debounces them, detects START, repeated START and STOP, and decodes each transaction into address, R/W, data bytes and ACK/NACK bits. It supersedes the single-purpose start/stop FSM and feeds the extender's forwarding and logging logic. It never drives the bus.

## Interface
- `FILTER_LEN`, 3: consecutive identical synchronised samples required before a filtered line changes (1..15).
- `SLAVE_ADDR`, 7'h50: 7-bit address compared for `addr_match`.
- `CNT_W`, 8: width of `byte_cnt`.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sda`  in  1  raw asynchronous bus data.
- `scl`  in  1  raw asynchronous bus clock.
- `start_p`  out  1  one-cycle pulse on START or repeated START.
- `stop_p`  out  1  one-cycle pulse on STOP.
- `busy`  out  1  high from START until STOP.
- `addr`  out  7  last received address, held.
- `rw`  out  1  last R/W bit, held (1 = read).
- `addr_valid`  out  1  one-cycle pulse when `addr`/`rw` are updated.
- `addr_match`  out  1  `addr == SLAVE_ADDR`, held with `addr`.
- `data`  out  8  last received data byte, held.
- `data_valid`  out  1  one-cycle pulse when `data` is updated.
- `ack`  out  1  last 9th-bit value, held (1 = ACK, i.e. SDA low).
- `ack_valid`  out  1  one-cycle pulse when `ack` is updated.
- `byte_cnt`  out  CNT_W  data bytes since the last address, saturating.
- `frame_err`  out  1  one-cycle pulse on START/STOP inside a byte.

## Operation
- Line conditioning per line: 2-flop synchroniser, then glitch filter. The filtered value `f` takes the synchronised value `s` only after `s != f` for FILTER_LEN consecutive cycles. Any sample with `s == f` clears the counter.
- Edge detection on registered previous filtered values (`sda_q`, `scl_q`):
  - START: `scl_f & scl_q & sda_q & !sda_f`.
  - STOP: `scl_f & scl_q & !sda_q & sda_f`.
  - SCL rise: `scl_f & !scl_q`.
- Bits sample `sda_f` on the SCL rise, MSB first. A 3-bit `bit_cnt` counts 0..7.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK.
  - IDLE: START → ADDR, `bit_cnt` = 0. SCL rises are ignored.
  - ADDR: 8 rises shift `{addr, rw}`. On the 8th rise, pulse `addr_valid`, update `addr_match`, clear `byte_cnt`, go to ADDR_ACK.
  - ADDR_ACK: next rise captures `ack`, pulses `ack_valid`, then goes to DATA.
  - DATA: 8 rises shift a byte. On the 8th rise, pulse `data_valid` and increment `byte_cnt` (saturating at 2^CNT_W−1), then go to DATA_ACK.
  - DATA_ACK: next rise captures `ack` and pulses `ack_valid`, then returns to DATA. After a NACK, stay in DATA; the next START or STOP ends the transfer.
- START in any non-IDLE state (repeated START): pulse `start_p`, go to ADDR, `bit_cnt` = 0.
- STOP in any state: pulse `stop_p`, go to IDLE, drop `busy`. A STOP while in IDLE still pulses `stop_p`.
- `frame_err` pulses when START or STOP occurs in ADDR/DATA with `bit_cnt != 0`, or in ADDR_ACK/DATA_ACK. The START/STOP transition itself still occurs.
- Priority: START/STOP over bit sampling. START and SCL rise cannot coincide, since START needs SCL high on two samples.

## Timing
- Reset (`reset` low at a `clk` edge):
  - All pulses, `busy`, `addr`, `rw`, `addr_match`, `data`, `ack` and `byte_cnt` = 0.
  - State IDLE, `bit_cnt` = 0.
  - Synchroniser, filtered and previous values = 1 (idle bus), so no spurious START/STOP on release.
- Pin-to-filtered latency: 2 + FILTER_LEN cycles.
- Event pulses (`start_p`, `stop_p`, `*_valid`, `frame_err`) assert in the cycle after the filtered edge is registered, i.e. 3 + FILTER_LEN cycles after a clean pin edge. They last exactly one cycle.
- Held outputs change in the same cycle as their `*_valid` pulse.
- Bus constraint: SCL high and low phases must each exceed FILTER_LEN + 3 clk cycles.
- Reset mid-transfer aborts decoding. Decoding resumes only after a fresh START.

## Structure
- Package `i2c_pkg`:
  - State encoding localparams (3-bit).
  - Constants `I2C_ADDR_W` = 7 and `I2C_BYTE_W` = 8.
- Sub-module `i2c_line_filter` (params `FILTER_LEN`, `RESET_VAL`): synchroniser + glitch filter. Instantiated once for SDA and once for SCL.

## Test plan
- Write 0x50 then data 0xA5 and 0x3C, each ACKed, then STOP → `addr_valid` with addr = 0x50, rw = 0, `addr_match` = 1; `data_valid` twice, data = 0xA5 then 0x3C; `ack_valid` ×3, all ack = 1; `byte_cnt` = 2; one `stop_p`; `busy` falls.
- Write 0x50 with data 0x01, then repeated START, read 0x51 → two `start_p` without an intervening `stop_p`; second `addr_valid` with addr = 0x28, rw = 1, `addr_match` = 0; `byte_cnt` resets to 0.
- SDA glitch of FILTER_LEN−1 cycles while SCL is high → no `start_p`/`stop_p`. Glitch of FILTER_LEN+1 cycles → `start_p` fires.
- STOP after 4 address bits → `frame_err` and `stop_p` in the same cycle; no `addr_valid`; state IDLE.
- Reset asserted mid-byte, then released with lines high → all outputs 0, no pulses. The next full transaction decodes correctly.
- With CNT_W = 2, send 5 data bytes → `byte_cnt` saturates at 3.
